// File: rtl/regfile_sb_m2.sv
// regfile_sb_m2: decode-stage register file with a tagged reservation scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-edge writebacks into the read ports.
module regfile_sb_m2 #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 16,
  parameter int READ_PORTS = 3,
  parameter int TAG_W      = 3,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         async_rst,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic                         reserve,
  input  logic [AW-1:0]                reserve_addr,
  input  logic [TAG_W-1:0]             reserve_tag,
  input  logic [READ_PORTS*AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0]            r0_const,
  output logic [READ_PORTS*DATA_W-1:0] rd_data,
  output logic [READ_PORTS-1:0]        rd_busy,
  input  logic                         wb0_en,
  input  logic [AW-1:0]                wb0_addr,
  input  logic [TAG_W-1:0]             wb0_tag,
  input  logic [DATA_W-1:0]            wb0_data,
  input  logic                         wb1_en,
  input  logic [AW-1:0]                wb1_addr,
  input  logic [TAG_W-1:0]             wb1_tag,
  input  logic [DATA_W-1:0]            wb1_data,
  output logic [AW:0]                  busy_count,
  output logic                         idle
);

  logic [DATA_W-1:0]            mem_q [NUM_REGS];
  logic [DATA_W-1:0]            mem_d [NUM_REGS];
  logic [TAG_W-1:0]             tag_q [NUM_REGS];
  logic [TAG_W-1:0]             tag_d [NUM_REGS];
  logic [NUM_REGS-1:0]          busy_q, busy_d;
  logic [READ_PORTS*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [READ_PORTS-1:0]        rd_busy_q, rd_busy_d;
  logic [AW:0]                  cnt_q, cnt_d;
  logic [AW-1:0]                ra;

  // Entry 0 is never written or reserved; wb1 is applied last so it wins.
  always_comb begin
    mem_d  = mem_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (wb0_en && wb0_addr == AW'(r)) begin
        mem_d[r] = wb0_data;
        if (tag_q[r] == wb0_tag) busy_d[r] = 1'b0;
      end
      if (wb1_en && wb1_addr == AW'(r)) begin
        mem_d[r] = wb1_data;
        if (tag_q[r] == wb1_tag) busy_d[r] = 1'b0;
      end
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (reserve && reserve_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = reserve_tag;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++)
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    ra        = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (ra == '0) begin
        rd_data_d[p*DATA_W +: DATA_W] = r0_const;
      end else begin
`ifdef REGFILE_SB_BYPASS_EN
        rd_data_d[p*DATA_W +: DATA_W] = mem_d[ra];
        rd_busy_d[p] = busy_d[ra];
`else
        // Conservative: a same-edge reserve shows busy, a same-edge clear does not.
        rd_data_d[p*DATA_W +: DATA_W] = mem_q[ra];
        rd_busy_d[p] = busy_q[ra] |
                       (reserve && !flush && reserve_addr == ra);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      busy_q    <= '0;
      tag_q     <= '{default: '0};
      rd_data_q <= '0;
      rd_busy_q <= '0;
      cnt_q     <= '0;
    end else if (clk_en) begin
      busy_q    <= busy_d;
      tag_q     <= tag_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) mem_q <= mem_d;
  end

  assign rd_data    = rd_data_q;
  assign rd_busy    = rd_busy_q;
  assign busy_count = cnt_q;
  assign idle       = (cnt_q == '0);

endmodule

// File: tb/tb_regfile_sb_m2.sv
// tb_regfile_sb_m2: vector table, directed corner sequences and random
// traffic against an array-based scoreboard model.
module tb_regfile_sb_m2;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        async_rst, clk_en, flush, reserve;
  logic [3:0]  reserve_addr;
  logic [2:0]  reserve_tag;
  logic [11:0] rd_addr;
  logic [15:0] r0_const;
  logic [47:0] rd_data;
  logic [2:0]  rd_busy;
  logic        wb0_en, wb1_en;
  logic [3:0]  wb0_addr, wb1_addr;
  logic [2:0]  wb0_tag, wb1_tag;
  logic [15:0] wb0_data, wb1_data;
  logic [4:0]  busy_count;
  logic        idle;

  regfile_sb_m2 dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .flush(flush),
    .reserve(reserve), .reserve_addr(reserve_addr),
    .reserve_tag(reserve_tag), .rd_addr(rd_addr), .r0_const(r0_const),
    .rd_data(rd_data), .rd_busy(rd_busy),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_tag(wb0_tag),
    .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_tag(wb1_tag),
    .wb1_data(wb1_data),
    .busy_count(busy_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_mem [16];
  bit          m_known [16];
  bit          m_busy [16];
  int          m_tag [16];
  logic [15:0] e_data [3];
  bit          e_busy [3];
  bit          e_known [3];
  int          e_cnt;

  typedef struct {
    bit res; int ra; int rt;
    bit w0e; int w0a; int w0t; logic [15:0] w0d;
    bit w1e; int w1a; int w1t; logic [15:0] w1d;
    bit fl; int rp;
    logic [15:0] ed; bit eb; int ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit res, int ra, int rt,
      bit w0e, int w0a, int w0t, logic [15:0] w0d,
      bit w1e, int w1a, int w1t, logic [15:0] w1d,
      bit fl, int rp, logic [15:0] ed, bit eb, int ec);
    vec_t t;
    t = '{res, ra, rt, w0e, w0a, w0t, w0d, w1e, w1a, w1t, w1d,
          fl, rp, ed, eb, ec};
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; reserve = 0; reserve_addr = 0; reserve_tag = 0;
    wb0_en = 0; wb0_addr = 0; wb0_tag = 0; wb0_data = 0;
    wb1_en = 0; wb1_addr = 0; wb1_tag = 0; wb1_data = 0;
    clk_en = 1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_busy[r] = 0;
      m_tag[r] = 0;
    end
    for (int p = 0; p < 3; p++) begin
      e_data[p] = 0; e_busy[p] = 0; e_known[p] = 1;
    end
    e_cnt = 0;
  endtask

  // Architectural rules: data always written, tag-matched clears,
  // reserve beats clear, flush beats reserve, r0 is a constant.
  task automatic model_step();
    logic [15:0] om [16];
    bit ok [16];
    bit ob [16];
    int ot [16];
    int a;
    if (!clk_en) return;
    om = m_mem; ok = m_known; ob = m_busy; ot = m_tag;
    if (wb0_en && wb0_addr != 0) begin
      a = int'(wb0_addr);
      m_mem[a] = wb0_data; m_known[a] = 1;
      if (ob[a] && ot[a] == int'(wb0_tag)) m_busy[a] = 0;
    end
    if (wb1_en && wb1_addr != 0) begin
      a = int'(wb1_addr);
      m_mem[a] = wb1_data; m_known[a] = 1;
      if (ob[a] && ot[a] == int'(wb1_tag)) m_busy[a] = 0;
    end
    if (flush) begin
      for (int r = 0; r < 16; r++) m_busy[r] = 0;
    end else if (reserve && reserve_addr != 0) begin
      m_busy[reserve_addr] = 1;
      m_tag[reserve_addr] = int'(reserve_tag);
    end
    e_cnt = 0;
    for (int r = 1; r < 16; r++) e_cnt += int'(m_busy[r]);
    for (int p = 0; p < 3; p++) begin
      a = int'(rd_addr[p*4 +: 4]);
      if (a == 0) begin
        e_data[p] = r0_const; e_busy[p] = 0; e_known[p] = 1;
      end else if (BYP) begin
        e_data[p] = m_mem[a]; e_busy[p] = m_busy[a]; e_known[p] = m_known[a];
      end else begin
        e_data[p] = om[a]; e_known[p] = ok[a];
        e_busy[p] = ob[a] | (reserve && !flush && int'(reserve_addr) == a);
      end
    end
  endtask

  task automatic check_model();
    for (int p = 0; p < 3; p++) begin
      if (e_known[p]) chk($sformatf("rd_data[%0d]", p),
                          32'(rd_data[p*16 +: 16]), 32'(e_data[p]));
      chk($sformatf("rd_busy[%0d]", p), 32'(rd_busy[p]), 32'(e_busy[p]));
    end
    chk("busy_count", 32'(busy_count), 32'(e_cnt));
    chk("idle", 32'(idle), 32'(e_cnt == 0));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic set_rd(int a);
    rd_addr = {4'((a + 2) % 16), 4'((a + 1) % 16), 4'(a)};
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      m_mem[r] = 0; m_known[r] = 0;
    end
    idle_inputs();
    r0_const = 16'hffff;
    rd_addr = 0;
    async_rst = 1;
    model_reset();
    #3;
    chk("rst busy_count", 32'(busy_count), 0);
    chk("rst idle", 32'(idle), 1);
    chk("rst rd_data", rd_data[31:0], 0);
    chk("rst rd_busy", 32'(rd_busy), 0);
    repeat (2) @(negedge clk);
    async_rst = 0;

    rd_addr = {4'd2, 4'd1, 4'd0};
    cycle();
    chk("r0 const", 32'(rd_data[15:0]), 32'h0000ffff);

    for (int r = 1; r < 16; r++) begin
      wb0_en = 1; wb0_addr = 4'(r); wb0_data = {8'(r), 8'(r)};
      set_rd(r);
      cycle();
    end
    idle_inputs();

    tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 16'hffff,1'b0,0));
    tbl.push_back(v(1,5,2, 0,0,0,0, 0,0,0,0, 0,5, 16'h0505,1'b1,1));
    tbl.push_back(v(0,0,0, 1,5,2,16'h1234, 0,0,0,0, 0,5,
                    BYP ? 16'h1234 : 16'h0505, BYP ? 1'b0 : 1'b1, 0));
    tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0, 0,5, 16'h1234,1'b0,0));
    tbl.push_back(v(1,7,1, 0,0,0,0, 0,0,0,0, 0,7, 16'h0707,1'b1,1));
    tbl.push_back(v(1,7,4, 0,0,0,0, 0,0,0,0, 0,7, 16'h0707,1'b1,1));
    tbl.push_back(v(0,0,0, 0,0,0,0, 1,7,1,16'haaaa, 0,7,
                    BYP ? 16'haaaa : 16'h0707, 1'b1, 1));
    tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0, 0,7, 16'haaaa,1'b1,1));
    tbl.push_back(v(0,0,0, 1,7,4,16'h5555, 0,0,0,0, 0,7,
                    BYP ? 16'h5555 : 16'haaaa, BYP ? 1'b0 : 1'b1, 0));
    tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0, 0,7, 16'h5555,1'b0,0));
    tbl.push_back(v(0,0,0, 1,3,0,16'h0011, 1,3,0,16'h0022, 0,3,
                    BYP ? 16'h0022 : 16'h0303, 1'b0, 0));
    tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0, 0,3, 16'h0022,1'b0,0));
    tbl.push_back(v(1,1,1, 0,0,0,0, 0,0,0,0, 0,1, 16'h0101,1'b1,1));
    tbl.push_back(v(1,2,1, 0,0,0,0, 0,0,0,0, 0,2, 16'h0202,1'b1,2));
    tbl.push_back(v(1,9,3, 0,0,0,0, 0,0,0,0, 0,9, 16'h0909,1'b1,3));
    tbl.push_back(v(1,4,2, 0,0,0,0, 0,0,0,0, 1,4, 16'h0404,1'b0,0));
    tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0, 0,1, 16'h0101,1'b0,0));
    tbl.push_back(v(1,0,1, 1,0,1,16'h9999, 0,0,0,0, 0,0, 16'hffff,1'b0,0));
    tbl.push_back(v(1,1,1, 0,0,0,0, 0,0,0,0, 0,1, 16'h0101,1'b1,1));
    tbl.push_back(v(1,1,6, 1,1,1,16'h4242, 0,0,0,0, 0,1,
                    BYP ? 16'h4242 : 16'h0101, 1'b1, 1));
    tbl.push_back(v(0,0,0, 1,1,1,16'h4343, 0,0,0,0, 0,1,
                    BYP ? 16'h4343 : 16'h4242, 1'b1, 1));
    tbl.push_back(v(0,0,0, 0,0,0,0, 1,1,6,16'h4444, 0,1,
                    BYP ? 16'h4444 : 16'h4343, BYP ? 1'b0 : 1'b1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reserve = tbl[i].res; reserve_addr = 4'(tbl[i].ra);
      reserve_tag = 3'(tbl[i].rt);
      wb0_en = tbl[i].w0e; wb0_addr = 4'(tbl[i].w0a);
      wb0_tag = 3'(tbl[i].w0t); wb0_data = tbl[i].w0d;
      wb1_en = tbl[i].w1e; wb1_addr = 4'(tbl[i].w1a);
      wb1_tag = 3'(tbl[i].w1t); wb1_data = tbl[i].w1d;
      flush = tbl[i].fl;
      set_rd(tbl[i].rp);
      cycle();
      chk($sformatf("vec%0d data", i), 32'(rd_data[15:0]), 32'(tbl[i].ed));
      chk($sformatf("vec%0d busy", i), 32'(rd_busy[0]), 32'(tbl[i].eb));
      chk($sformatf("vec%0d count", i), 32'(busy_count), 32'(tbl[i].ec));
    end
    idle_inputs();

    // Stall: a flush, reserve and writeback under clk_en=0 change nothing.
    reserve = 1; reserve_tag = 2;
    reserve_addr = 1; set_rd(1); cycle();
    reserve_addr = 2; set_rd(2); cycle();
    reserve_addr = 9; set_rd(9); cycle();
    chk("pre-stall count", 32'(busy_count), 3);
    clk_en = 0; flush = 1; reserve_addr = 4; set_rd(4);
    wb0_en = 1; wb0_addr = 9; wb0_tag = 2; wb0_data = 16'hdead;
    cycle();
    chk("stall count", 32'(busy_count), 3);
    chk("stall rd_data", 32'(rd_data[15:0]), 32'h00000909);
    chk("stall rd_busy", 32'(rd_busy[0]), 1);
    wb0_en = 0; clk_en = 1;
    cycle();
    chk("flush count", 32'(busy_count), 0);
    chk("flush r4 busy", 32'(rd_busy[0]), 0);
    idle_inputs();

    // Asynchronous reset in the middle of a cycle drops reservations.
    reserve = 1; reserve_addr = 6; reserve_tag = 5; set_rd(6);
    cycle();
    chk("pre-rst count", 32'(busy_count), 1);
    idle_inputs();
    #2 async_rst = 1;
    #1;
    model_reset();
    chk("mid-rst rd_data", rd_data[31:0], 0);
    chk("mid-rst rd_busy", 32'(rd_busy), 0);
    chk("mid-rst count", 32'(busy_count), 0);
    chk("mid-rst idle", 32'(idle), 1);
    @(negedge clk);
    async_rst = 0;
    set_rd(6);
    cycle();
    chk("post-rst r6 busy", 32'(rd_busy[0]), 0);
    chk("post-rst r6 data", 32'(rd_data[15:0]), 32'h00000606);

    for (int i = 0; i < 400; i++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      reserve = $urandom_range(0, 1);
      reserve_addr = 4'($urandom_range(0, 15));
      reserve_tag = 3'($urandom_range(0, 3));
      wb0_en = $urandom_range(0, 1);
      wb0_addr = 4'($urandom_range(0, 15));
      wb0_tag = 3'($urandom_range(0, 3));
      wb0_data = 16'($urandom);
      wb1_en = $urandom_range(0, 1);
      wb1_addr = 4'($urandom_range(0, 15));
      wb1_tag = 3'($urandom_range(0, 3));
      wb1_data = 16'($urandom);
      rd_addr = 12'($urandom);
      r0_const = 16'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
